// File: rtl/axi_stream_head_body_split_pkg.sv
// axi_stream_head_body_split_pkg: shared helper for AXI-stream side-band widths
package axi_stream_head_body_split_pkg;

    // tkeep width for a given tdata width, never narrower than one bit
    function automatic int ksize(input int dsize);
        return (dsize / 8 > 0) ? dsize / 8 : 1;
    endfunction

endpackage

// File: rtl/axi_stream_head_body_split_if.sv
// axi_stream_inf: AXI-stream bundle carrying its own clock, reset and clock enable
interface axi_stream_inf
    import axi_stream_head_body_split_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input logic aclk,
    input logic aresetn,
    input logic aclken
);

    localparam int KSIZE = ksize(DSIZE);

    logic [DSIZE-1:0] tdata;
    logic [KSIZE-1:0] tkeep;
    logic             tuser;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (
        input  aclk, aresetn, aclken, tready,
        output tdata, tkeep, tuser, tlast, tvalid
    );

    modport slaver (
        input  aclk, aresetn, aclken, tdata, tkeep, tuser, tlast, tvalid,
        output tready
    );

endinterface

// File: rtl/axis_reg_slice_1.sv
// axis_reg_slice_1: one-entry output register that holds its payload while stalled
module axis_reg_slice_1 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_payload,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_payload
);

    logic         valid_q, valid_d;
    logic [W-1:0] payload_q, payload_d;

    assign s_ready   = !valid_q || m_ready;
    assign m_valid   = valid_q;
    assign m_payload = payload_q;

    // load a new beat when accepted, otherwise retire the held beat once taken
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (en && s_valid && s_ready) begin
            valid_d   = 1'b1;
            payload_d = s_payload;
        end else if (en && m_ready) begin
            valid_d = 1'b0;
        end
    end

    // register with asynchronous clear that discards any in-flight beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

endmodule

// File: rtl/axi_stream_head_body_split.sv
// axi_stream_head_body_split: routes the first head_len beats of each packet to head_inf, the rest to body_inf
module axi_stream_head_body_split
    import axi_stream_head_body_split_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic [15:0]        head_len,
    axi_stream_inf.slaver      s00,
    axi_stream_inf.master      head_inf,
    axi_stream_inf.master      body_inf,
    output logic               short_pkt
);

    localparam int KSIZE = ksize(DSIZE);
    localparam int W     = DSIZE + KSIZE + 2;

    typedef enum logic {HEAD, BODY} state_t;

    state_t      state_q, state_d;
    logic [15:0] hcnt_q, hcnt_d;
    logic [15:0] len_q, len_d;
    logic        short_q, short_d;
    logic        first, to_body, head_hit, acc, h_load, b_load, h_ready, b_ready;
    logic [15:0] len_eff;
    logic [W-1:0] h_in, b_in, h_out, b_out;

    // a packet start in HEAD uses the live head_len; later beats use the latched length
    assign first    = (state_q == HEAD) && (hcnt_q == 16'd0);
    assign len_eff  = first ? head_len : len_q;
    assign to_body  = (state_q == BODY) || (first && head_len == 16'd0);
    assign head_hit = hcnt_q == len_eff - 16'd1;

    // FSM, beat counter, latched length and short-packet pulse registers
    always_ff @(posedge s00.aclk or negedge s00.aresetn) begin
        if (!s00.aresetn) begin
            state_q <= HEAD;
            hcnt_q  <= '0;
            len_q   <= '0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            len_q   <= len_d;
            short_q <= short_d;
        end
    end

    // next state: advance through the head, switch to body on the last head beat, return on tlast
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        len_d   = len_q;
        if (acc && first)
            len_d = head_len;
        if (b_load) begin
            state_d = s00.tlast ? HEAD : BODY;
            hcnt_d  = '0;
        end else if (h_load) begin
            state_d = (head_hit && !s00.tlast) ? BODY : HEAD;
            hcnt_d  = (head_hit || s00.tlast) ? 16'd0 : hcnt_q + 16'd1;
        end
    end

    // outputs: ready follows the selected slice only, beats are steered, short packets flagged
    always_comb begin
        s00.tready = s00.aclken && (to_body ? b_ready : h_ready);
        acc        = s00.tvalid && s00.tready;
        h_load     = acc && !to_body;
        b_load     = acc && to_body;
        short_d    = s00.aclken ? (h_load && s00.tlast && hcnt_q < len_eff - 16'd1) : short_q;
        h_in       = {s00.tuser, s00.tlast || head_hit, s00.tkeep, s00.tdata};
        b_in       = {s00.tuser, s00.tlast, s00.tkeep, s00.tdata};
    end

    assign short_pkt = short_q;

    axis_reg_slice_1 #(.W(W)) u_head (
        .clk       (s00.aclk),
        .rst_n     (s00.aresetn),
        .en        (s00.aclken),
        .s_valid   (h_load),
        .s_ready   (h_ready),
        .s_payload (h_in),
        .m_valid   (head_inf.tvalid),
        .m_ready   (head_inf.tready),
        .m_payload (h_out)
    );

    axis_reg_slice_1 #(.W(W)) u_body (
        .clk       (s00.aclk),
        .rst_n     (s00.aresetn),
        .en        (s00.aclken),
        .s_valid   (b_load),
        .s_ready   (b_ready),
        .s_payload (b_in),
        .m_valid   (body_inf.tvalid),
        .m_ready   (body_inf.tready),
        .m_payload (b_out)
    );

    assign {head_inf.tuser, head_inf.tlast, head_inf.tkeep, head_inf.tdata} = h_out;
    assign {body_inf.tuser, body_inf.tlast, body_inf.tkeep, body_inf.tdata} = b_out;

endmodule

// File: tb/tb_axi_stream_head_body_split.sv
// tb_axi_stream_head_body_split: directed scoreboard bench for the head/body splitter
module tb_axi_stream_head_body_split;

    localparam int DSIZE = 8;
    typedef logic [DSIZE+2:0] ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        aclken = 1'b1;
    logic [15:0] head_len = '0;
    logic        short_pkt;

    int   compared = 0;
    int   mismatched = 0;
    int   short_seen = 0;
    int   short_exp = 0;
    bit   rnd_bp = 1'b0;
    bit   h_stall = 1'b0;
    bit   b_stall = 1'b0;
    ent_t h_hold, b_hold, ho, bo, h_exp, b_exp;
    ent_t hq[$];
    ent_t bq[$];

    always #5 clk = ~clk;

    axi_stream_inf #(.DSIZE(DSIZE)) s00 (.aclk(clk), .aresetn(rst_n), .aclken(aclken));
    axi_stream_inf #(.DSIZE(DSIZE)) hd  (.aclk(clk), .aresetn(rst_n), .aclken(aclken));
    axi_stream_inf #(.DSIZE(DSIZE)) bd  (.aclk(clk), .aresetn(rst_n), .aclken(aclken));

    axi_stream_head_body_split #(.DSIZE(DSIZE)) dut (
        .head_len  (head_len),
        .s00       (s00),
        .head_inf  (hd),
        .body_inf  (bd),
        .short_pkt (short_pkt)
    );

    assign ho = {hd.tuser, hd.tlast, hd.tkeep, hd.tdata};
    assign bo = {bd.tuser, bd.tlast, bd.tkeep, bd.tdata};

    initial begin
        hd.tready = 1'b1;
        bd.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            hd.tready = rnd_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            bd.tready = rnd_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            h_stall = 1'b0;
            b_stall = 1'b0;
        end else begin
            if (h_stall) begin
                compared++;
                assert (hd.tvalid === 1'b1 && ho === h_hold) else begin
                    mismatched++;
                    $error("FAIL head_stable obs=%b/%h exp=1/%h", hd.tvalid, ho, h_hold);
                end
            end
            if (b_stall) begin
                compared++;
                assert (bd.tvalid === 1'b1 && bo === b_hold) else begin
                    mismatched++;
                    $error("FAIL body_stable obs=%b/%h exp=1/%h", bd.tvalid, bo, b_hold);
                end
            end
            if (aclken && hd.tvalid && hd.tready) begin
                h_exp = (hq.size() > 0) ? hq.pop_front() : 'x;
                compared++;
                assert (ho === h_exp) else begin
                    mismatched++;
                    $error("FAIL head_beat obs=%h exp=%h", ho, h_exp);
                end
            end
            if (aclken && bd.tvalid && bd.tready) begin
                b_exp = (bq.size() > 0) ? bq.pop_front() : 'x;
                compared++;
                assert (bo === b_exp) else begin
                    mismatched++;
                    $error("FAIL body_beat obs=%h exp=%h", bo, b_exp);
                end
            end
            h_stall = aclken && hd.tvalid && !hd.tready;
            b_stall = aclken && bd.tvalid && !bd.tready;
            h_hold  = ho;
            b_hold  = bo;
            if (short_pkt)
                short_seen++;
        end
    end

    task automatic send(input int n, input logic [15:0] hl0, input logic [15:0] hl_rest,
                        input logic [7:0] base, input int stop);
        logic [7:0] d;
        ent_t       e;
        int         cnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < stop; i++) begin
            d          = base + 8'(i);
            s00.tvalid = 1'b1;
            s00.tdata  = d;
            s00.tkeep  = d[0];
            s00.tuser  = d[1];
            s00.tlast  = (i == n - 1);
            head_len   = (i == 0) ? hl0 : hl_rest;
            cnt        = 0;
            @(negedge clk);
            while (!s00.tready && cnt < 200) begin
                @(negedge clk);
                cnt++;
            end
            compared++;
            assert (cnt < 200) else begin
                mismatched++;
                $error("FAIL accept_timeout beat=%0d waited=%0d limit=200", i, cnt);
            end
            if (hl0 != 0 && i < int'(hl0)) begin
                e = {d[1], 1'b1 == (i == int'(hl0) - 1 || i == n - 1), d[0], d};
                hq.push_back(e);
            end else begin
                e = {d[1], 1'b1 == (i == n - 1), d[0], d};
                bq.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        s00.tvalid = 1'b0;
        if (stop == n && hl0 != 0 && n < int'(hl0))
            short_exp++;
    endtask

    task automatic drain(input string tag);
        int cnt;
        cnt = 0;
        @(negedge clk);
        while ((hq.size() != 0 || bq.size() != 0 || hd.tvalid || bd.tvalid) && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        @(negedge clk);
        compared++;
        assert (hq.size() + bq.size() == 0) else begin
            mismatched++;
            $error("FAIL %s_drain left=%0d exp=0", tag, hq.size() + bq.size());
        end
        compared++;
        assert (short_seen == short_exp) else begin
            mismatched++;
            $error("FAIL %s_short obs=%0d exp=%0d", tag, short_seen, short_exp);
        end
    endtask

    initial begin
        s00.tvalid = 1'b0;
        s00.tdata  = '0;
        s00.tkeep  = '0;
        s00.tuser  = 1'b0;
        s00.tlast  = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        assert (hd.tvalid === 1'b0 && bd.tvalid === 1'b0) else begin
            mismatched++;
            $error("FAIL reset_valid obs=%b%b exp=00", hd.tvalid, bd.tvalid);
        end
        compared++;
        assert (short_pkt === 1'b0) else begin
            mismatched++;
            $error("FAIL reset_short obs=%b exp=0", short_pkt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        assert (s00.tready === 1'b1) else begin
            mismatched++;
            $error("FAIL idle_ready obs=%b exp=1", s00.tready);
        end

        send(10, 4, 4, 8'h10, 10);
        drain("long");
        send(3, 4, 4, 8'h20, 3);
        drain("short");
        send(4, 4, 4, 8'h30, 4);
        drain("exact");
        send(5, 0, 0, 8'h40, 5);
        drain("nohead");
        send(3, 1, 1, 8'h48, 3);
        drain("onehead");

        aclken     = 1'b0;
        s00.tvalid = 1'b1;
        s00.tdata  = 8'hee;
        repeat (3) begin
            @(negedge clk);
            compared++;
            assert (s00.tready === 1'b0 && hd.tvalid === 1'b0 && bd.tvalid === 1'b0) else begin
                mismatched++;
                $error("FAIL clken_hold obs=%b%b%b exp=000", s00.tready, hd.tvalid, bd.tvalid);
            end
        end
        s00.tvalid = 1'b0;
        aclken     = 1'b1;

        rnd_bp = 1'b1;
        send(8, 4, 2, 8'h50, 8);
        send(6, 2, 2, 8'h60, 6);
        send(5, 2, 2, 8'h70, 5);
        send(1, 2, 2, 8'h78, 1);
        send(7, 3, 1, 8'h80, 7);
        drain("backpressure");
        rnd_bp = 1'b0;

        send(10, 4, 4, 8'ha0, 6);
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        assert (hd.tvalid === 1'b0 && bd.tvalid === 1'b0) else begin
            mismatched++;
            $error("FAIL midreset_valid obs=%b%b exp=00", hd.tvalid, bd.tvalid);
        end
        hq.delete();
        bq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(10, 4, 4, 8'hc0, 10);
        drain("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
